fb_mode_sequencer: RTL and testbench

//  Sequences framebuffer reconfiguration when the scale selector changes.

---
 rtl/fb_pkg.sv | 22 ++
 rtl/sw_filter.sv | 67 ++++++
 rtl/fb_mode_sequencer.sv | 175 +++++++++++++++++
 tb/tb_fb_mode_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer mode sequencer: FSM states, scale mode codes and
// default framebuffer geometry.
package fb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitFs,
    StClear,
    StCopy,
    StDone
  } fb_state_e;

  // Scale mode codes as seen by the display-side geometry logic.
  localparam logic [1:0] MODE_X2   = 2'b00;
  localparam logic [1:0] MODE_HALF = 2'b01;
  localparam logic [1:0] MODE_X1   = 2'b10;

  // 320x240 is the largest scaled image held in the framebuffer.
  localparam int unsigned FB_DEPTH = 76800;
  localparam int unsigned ADDR_W   = 19;

endpackage

// File: rtl/sw_filter.sv
// Scale selector filter: 2-flop synchroniser followed by a stability counter. A value that
// differs from the last accepted one and holds for STABLE_CYCLES cycles is accepted, raising
// a 1-cycle req pulse; req_mode always shows the last accepted value.
module sw_filter
  import fb_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sw,
  output logic       req,
  output logic [1:0] req_mode
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 1);

  logic [1:0]      sync1_q, sync2_q;
  logic [1:0]      cand_q, cand_d;
  logic [1:0]      acc_q, acc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            req_q, req_d;

  // Synchroniser and filter state; reset matches the 1:1 mode committed at reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= MODE_X1;
      sync2_q <= MODE_X1;
      cand_q  <= MODE_X1;
      acc_q   <= MODE_X1;
      cnt_q   <= '0;
      req_q   <= 1'b0;
    end else begin
      sync1_q <= sw;
      sync2_q <= sync1_q;
      cand_q  <= cand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  // Any change restarts the count; a stable new value is accepted once the count expires.
  always_comb begin
    cand_d = cand_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    req_d  = 1'b0;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cand_q == acc_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      acc_d = cand_q;
      cnt_d = '0;
      req_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign req      = req_q;
  assign req_mode = acc_q;

endmodule

// File: rtl/fb_mode_sequencer.sv
// Framebuffer reconfiguration sequencer: on a filtered scale change it waits for a frame
// boundary, blanks the display, clears the RAM and starts the ROM->RAM copier, owning the
// framebuffer write port throughout.
// Build option FB_CLEAR_EN: when defined the RAM is cleared to BG_COLOR before each copy;
// when undefined the clear stage is removed and WAIT_FS goes straight to COPY.
module fb_mode_sequencer #(
  parameter int unsigned FB_DEPTH      = fb_pkg::FB_DEPTH,
  parameter int unsigned ADDR_W        = fb_pkg::ADDR_W,
  parameter int unsigned STABLE_CYCLES = 250000,
  parameter logic [7:0]  BG_COLOR      = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        sw,
  input  logic              frame_start,
  input  logic              copy_done,
  input  logic [ADDR_W-1:0] cp_wr_addr,
  input  logic [7:0]        cp_wr_data,
  input  logic              cp_wr_en,
  output logic              copy_start,
  output logic [1:0]        mode,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              wr_en,
  output logic              blank_display,
  output logic              busy
);

  import fb_pkg::*;

  if (FB_DEPTH == 0 || FB_DEPTH > (32'd1 << ADDR_W)) begin : g_bad_depth
    $error("fb_mode_sequencer: FB_DEPTH does not fit the address space");
  end

  logic       filt_req;
  logic [1:0] filt_mode;

  sw_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_sw_filter (
    .clk      (clk),
    .reset    (reset),
    .sw       (sw),
    .req      (filt_req),
    .req_mode (filt_mode)
  );

  fb_state_e  state_q, state_d;
  logic       pending_q, pending_d;   // forces a first load after reset
  logic       req_q, req_d;           // request waiting to be served
  logic [1:0] next_mode_q, next_mode_d;
  logic [1:0] mode_q, mode_d;
  logic       blank_q, blank_d;
  logic       copy_start_q, copy_start_d;
  logic       copy_done_q;
`ifdef FB_CLEAR_EN
  localparam logic [ADDR_W-1:0] ClrLast = ADDR_W'(FB_DEPTH - 1);
  logic [ADDR_W-1:0] clr_q, clr_d;
`endif

  // Sequencer state; reset aborts any sequence in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      pending_q    <= 1'b1;
      req_q        <= 1'b0;
      next_mode_q  <= MODE_X1;
      mode_q       <= MODE_X1;
      blank_q      <= 1'b1;
      copy_start_q <= 1'b0;
      copy_done_q  <= 1'b0;
`ifdef FB_CLEAR_EN
      clr_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      req_q        <= req_d;
      next_mode_q  <= next_mode_d;
      mode_q       <= mode_d;
      blank_q      <= blank_d;
      copy_start_q <= copy_start_d;
      copy_done_q  <= copy_done;
`ifdef FB_CLEAR_EN
      clr_q        <= clr_d;
`endif
    end
  end

  // Next-state: a request arriving mid-sequence is kept and served after DONE.
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    req_d        = req_q | filt_req;
    next_mode_d  = next_mode_q;
    mode_d       = mode_q;
    blank_d      = blank_q;
    copy_start_d = 1'b0;
`ifdef FB_CLEAR_EN
    clr_d        = clr_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req_q || pending_q) begin
          state_d     = StWaitFs;
          next_mode_d = filt_mode;
          req_d       = filt_req;
          pending_d   = 1'b0;
          blank_d     = 1'b1;
        end
      end
      StWaitFs: begin
        if (frame_start) begin
`ifdef FB_CLEAR_EN
          state_d = StClear;
          clr_d   = '0;
`else
          state_d      = StCopy;
          copy_start_d = 1'b1;
          mode_d       = next_mode_q;
`endif
        end
      end
`ifdef FB_CLEAR_EN
      StClear: begin
        clr_d = clr_q + 1'b1;
        if (clr_q == ClrLast) begin
          state_d      = StCopy;
          copy_start_d = 1'b1;
          mode_d       = next_mode_q;
        end
      end
`endif
      StCopy: begin
        // A done level left over from the previous copy must not end this one.
        if (!copy_start_q && copy_done && !copy_done_q) state_d = StDone;
      end
      StDone: begin
        if (req_q) begin
          state_d     = StWaitFs;
          next_mode_d = filt_mode;
          req_d       = filt_req;
        end else begin
          state_d = StIdle;
          blank_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Write-port mux: copier passes straight through in COPY, clear engine drives CLEAR.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = BG_COLOR;
    if (state_q == StCopy) begin
      wr_en   = cp_wr_en;
      wr_addr = cp_wr_addr;
      wr_data = cp_wr_data;
    end
`ifdef FB_CLEAR_EN
    else if (state_q == StClear) begin
      wr_en   = 1'b1;
      wr_addr = clr_q;
    end
`endif
  end

  assign copy_start    = copy_start_q;
  assign mode          = mode_q;
  assign blank_display = blank_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_fb_mode_sequencer.sv
// Self-checking bench for fb_mode_sequencer. Framebuffer writes are scoreboarded: expected
// clear and copier writes are queued when stimulus is driven and popped by a monitor.
module tb_fb_mode_sequencer;
  import fb_pkg::*;

  localparam int unsigned AW     = 19;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned STABLE = 8;
  localparam logic [7:0]  BG     = 8'h00;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    sw;
  logic          frame_start;
  logic          copy_done;
  logic [AW-1:0] cp_wr_addr;
  logic [7:0]    cp_wr_data;
  logic          cp_wr_en;
  logic          copy_start;
  logic [1:0]    mode;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          wr_en;
  logic          blank_display;
  logic          busy;

  fb_mode_sequencer #(
    .FB_DEPTH      (DEPTH),
    .ADDR_W        (AW),
    .STABLE_CYCLES (STABLE),
    .BG_COLOR      (BG)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .sw            (sw),
    .frame_start   (frame_start),
    .copy_done     (copy_done),
    .cp_wr_addr    (cp_wr_addr),
    .cp_wr_data    (cp_wr_data),
    .cp_wr_en      (cp_wr_en),
    .copy_start    (copy_start),
    .mode          (mode),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_en         (wr_en),
    .blank_display (blank_display),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            cs_count = 0;
  int            exp_cs   = 0;
  logic [AW+7:0] exp_q[$];
  logic [AW+7:0] mon_e;
  bit            seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: every framebuffer write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (copy_start === 1'b1) cs_count++;
    if (wr_en !== 1'b0) begin
      if (exp_q.size() == 0) begin
        check("wr_unexp", 32'(wr_en), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr", 32'({wr_addr, wr_data}), 32'(mon_e));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
  endtask

  task automatic wait_busy(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b1 && n < 60) begin
      tick(1);
      n++;
    end
    check(tag, 32'(busy), 32'd1);
  endtask

  // One full load: frame boundary, optional clear, copy with a few copier writes, done.
  task automatic run_seq(input logic [1:0] exp_mode, input logic exp_busy_after,
                         input bit sw_mid);
    logic [7:0] d;
    wait_busy("seq_busy");
    tick(2);
    check("wait_blank", 32'(blank_display), 32'd1);
    check("wait_nowr", 32'(wr_en), 32'd0);
`ifdef FB_CLEAR_EN
    for (int i = 0; i < int'(DEPTH); i++) exp_q.push_back({AW'(i), BG});
`endif
    pulse_fs();
`ifdef FB_CLEAR_EN
    tick(DEPTH);
`endif
    check("copy_start", 32'(copy_start), 32'd1);
    check("mode", 32'(mode), 32'(exp_mode));
    exp_cs++;
    tick(1);
    check("cs_pulse", 32'(copy_start), 32'd0);
    if (sw_mid) begin
      sw = MODE_HALF;
      tick(14);
      sw = MODE_X2;
      tick(14);
      check("copy_held", 32'(busy), 32'd1);
    end
    for (int i = 0; i < 3; i++) begin
      d          = 8'($urandom);
      cp_wr_en   = 1'b1;
      cp_wr_addr = AW'(200 + i);
      cp_wr_data = d;
      exp_q.push_back({AW'(200 + i), d});
      tick(1);
    end
    cp_wr_en  = 1'b0;
    copy_done = 1'b1;
    tick(1);
    check("done_busy", 32'(busy), 32'd1);
    check("done_blank", 32'(blank_display), 32'd1);
    tick(1);
    check("post_blank", 32'(blank_display), 32'(exp_busy_after));
    check("post_busy", 32'(busy), 32'(exp_busy_after));
    copy_done = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b0;
    sw          = MODE_X1;
    frame_start = 1'b0;
    copy_done   = 1'b0;
    cp_wr_addr  = '0;
    cp_wr_data  = '0;
    cp_wr_en    = 1'b0;

    // 1: reset values, then the automatic first load in 1:1 mode.
    tick(3);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_mode", 32'(mode), 32'(MODE_X1));
    check("rst_blank", 32'(blank_display), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cs", 32'(copy_start), 32'd0);
    reset = 1'b1;
    tick(1);
    check("pending_busy", 32'(busy), 32'd1);
    run_seq(MODE_X1, 1'b0, 1'b0);
    check("first_cs_count", 32'(cs_count), 32'd1);

    // 2: accepted change to x2.
    sw = MODE_X2;
    run_seq(MODE_X2, 1'b0, 1'b0);

    // 3: short glitch must not be accepted.
    sw = MODE_HALF;
    tick(5);
    sw = MODE_X2;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (busy !== 1'b0) seen = 1'b1;
    end
    check("glitch_busy", 32'(seen), 32'd0);
    check("glitch_wr_en", 32'(wr_en), 32'd0);

    // 4: two changes during COPY collapse into one extra sequence, last one wins.
    sw = MODE_X1;
    run_seq(MODE_X1, 1'b1, 1'b1);
    run_seq(MODE_X2, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (busy !== 1'b0) seen = 1'b1;
    end
    check("no_third_seq", 32'(seen), 32'd0);

    // 5: reset in the middle of a load, then a full reload.
    sw = MODE_HALF;
    wait_busy("abort_busy");
    tick(2);
`ifdef FB_CLEAR_EN
    for (int i = 0; i < 8; i++) exp_q.push_back({AW'(i), BG});
    pulse_fs();
    tick(7);
    check("clr_addr7", 32'(wr_addr), 32'd7);
`else
    pulse_fs();
    exp_cs++;
    tick(3);
`endif
    reset = 1'b0;
    sw    = MODE_X1;
    tick(1);
    check("abort_wr_en", 32'(wr_en), 32'd0);
    check("abort_blank", 32'(blank_display), 32'd1);
    check("abort_busy0", 32'(busy), 32'd0);
    check("abort_mode", 32'(mode), 32'(MODE_X1));
    reset = 1'b1;
    run_seq(MODE_X1, 1'b0, 1'b0);

    // 6: copier writes outside COPY are dropped.
    cp_wr_en   = 1'b1;
    cp_wr_addr = AW'(5);
    cp_wr_data = 8'h5a;
    tick(1);
    check("idle_cp_drop", 32'(wr_en), 32'd0);
    cp_wr_en = 1'b0;

    tick(5);
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    check("cs_total", 32'(cs_count), 32'(exp_cs));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
